// File: rtl/ftq_unit.sv
// ftq_unit: Fetch Target Queue between the branch predictor and instruction fetch.
//
// Buffers predicted fetch blocks, hands them to fetch in order, records backend
// resolution per entry, raises a registered redirect on misprediction and emits a
// registered BTB training write when a resolved-taken entry commits.
//
// Ports:
//   Clk, Rest            clock, synchronous active-high reset
//   Bpu*                 predicted block in (valid/ready handshake)
//   Fetch*               head-of-fetch entry out (valid/ready handshake)
//   Resolve*             backend outcome for one entry per cycle
//   CommitValid          retire the oldest fetched entry
//   Redirect*            fetch restart, one cycle after a mispredict
//   Train*               BTB update, one cycle after a trained commit
//
// Optional build macro:
//   FTQ_FETCH_BYPASS_EN  forward Bpu* to Fetch* when the queue is fetch-empty
//                        (0-cycle enqueue-to-fetch latency).
module ftq_unit #(
   parameter int unsigned FTQ_DEPTH = 8,
   parameter int unsigned IDX_W     = 3
) (
   input  logic             Clk,
   input  logic             Rest,
   // predictor side
   input  logic             BpuValid,
   output logic             BpuReady,
   input  logic [31:0]      BpuPc,
   input  logic [31:0]      BpuNextPc,
   input  logic [2:0]       BpuType,
   input  logic [2:0]       BpuPosi,
   // fetch side
   output logic             FetchValid,
   input  logic             FetchReady,
   output logic [31:0]      FetchPc,
   output logic [31:0]      FetchNextPc,
   output logic [2:0]       FetchPosi,
   output logic [IDX_W-1:0] FetchIdx,
   // backend resolution
   input  logic             ResolveValid,
   input  logic [IDX_W-1:0] ResolveIdx,
   input  logic             ResolveTaken,
   input  logic [2:0]       ResolveType,
   input  logic [2:0]       ResolvePosi,
   input  logic [31:0]      ResolveTarget,
   input  logic             ResolveMispred,
   // commit
   input  logic             CommitValid,
   // redirect
   output logic             RedirectValid,
   output logic [31:0]      RedirectPc,
   // BTB training
   output logic             TrainValid,
   output logic [18:0]      TrainTage,
   output logic [2:0]       TrainType,
   output logic [2:0]       TrainPosi,
   output logic [31:0]      TrainTarget
);

   typedef logic [IDX_W:0]   ptr_t;
   typedef logic [IDX_W-1:0] idx_t;

   localparam ptr_t DepthPtr = ptr_t'(FTQ_DEPTH);
   localparam ptr_t PtrOne   = ptr_t'(1);

   // Pointers carry a wrap bit in the MSB.
   ptr_t enq_q, enq_d, fetch_q, fetch_d, cmt_q, cmt_d;

   // Entry storage
   logic [31:0]          pc_mem       [FTQ_DEPTH];
   logic [31:0]          next_pc_mem  [FTQ_DEPTH];
   logic [2:0]           pred_type_mem[FTQ_DEPTH];
   logic [2:0]           posi_mem     [FTQ_DEPTH];
   logic [FTQ_DEPTH-1:0] resolved_q, resolved_d;
   logic [FTQ_DEPTH-1:0] res_taken_q;
   logic [2:0]           res_type_mem  [FTQ_DEPTH];
   logic [2:0]           res_posi_mem  [FTQ_DEPTH];
   logic [31:0]          res_target_mem[FTQ_DEPTH];

   idx_t enq_idx, fetch_idx, cmt_idx, res_off;
   ptr_t occupancy, fetched, mispred_ptr;
   logic full, fetch_empty, cmt_empty, bypass;
   logic enq_fire, fetch_fire, cmt_fire, res_acc, mispred, res_hits_cmt;
   logic train_fire;
   logic [2:0]  train_type_d, train_posi_d;
   logic [31:0] train_target_d, redirect_pc_d;

   assign enq_idx   = enq_q[IDX_W-1:0];
   assign fetch_idx = fetch_q[IDX_W-1:0];
   assign cmt_idx   = cmt_q[IDX_W-1:0];

   assign occupancy   = enq_q - cmt_q;
   assign fetched     = fetch_q - cmt_q;
   assign full        = (occupancy == DepthPtr);
   assign fetch_empty = (fetch_q == enq_q);
   assign cmt_empty   = (cmt_q == fetch_q);

   // Resolve window is [cmt_ptr, fetch_ptr): compare the modular distance from
   // the commit pointer against the number of fetched-but-uncommitted entries.
   assign res_off     = ResolveIdx - cmt_idx;
   assign res_acc     = ResolveValid & ({1'b0, res_off} < fetched);
   assign mispred     = res_acc & ResolveMispred;
   // Rebuild a full pointer for the resolving entry so the wrap bit follows cmt_ptr.
   assign mispred_ptr = cmt_q + {1'b0, res_off} + PtrOne;

`ifdef FTQ_FETCH_BYPASS_EN
   assign bypass = fetch_empty & BpuValid;
`else
   assign bypass = 1'b0;
`endif

   // Blocked on the raw mispredict request so a same-cycle enqueue never races a flush.
   assign BpuReady   = ~full & ~(ResolveValid & ResolveMispred);
   assign enq_fire   = BpuValid & BpuReady;
   assign FetchValid = ~fetch_empty | bypass;
   // A bypassed block only counts as fetched if it is also written this cycle.
   assign fetch_fire = FetchValid & FetchReady & ~mispred & (~bypass | enq_fire);
   assign cmt_fire   = CommitValid & ~cmt_empty;

   always_comb begin
      FetchPc     = '0;
      FetchNextPc = '0;
      FetchPosi   = '0;
      FetchIdx    = '0;
      if (bypass) begin
         FetchPc     = BpuPc;
         FetchNextPc = BpuNextPc;
         FetchPosi   = BpuPosi;
         FetchIdx    = fetch_idx;
      end else if (!fetch_empty) begin
         FetchPc     = pc_mem[fetch_idx];
         FetchNextPc = next_pc_mem[fetch_idx];
         FetchPosi   = posi_mem[fetch_idx];
         FetchIdx    = fetch_idx;
      end
   end

   // Training: a resolve landing on the committing entry wins over stored state.
   assign res_hits_cmt = res_acc & (ResolveIdx == cmt_idx);

   always_comb begin
      train_fire     = 1'b0;
      train_type_d   = res_type_mem[cmt_idx];
      train_posi_d   = res_posi_mem[cmt_idx];
      train_target_d = res_target_mem[cmt_idx];
      if (res_hits_cmt) begin
         train_fire     = cmt_fire & ResolveTaken;
         train_type_d   = ResolveType;
         train_posi_d   = ResolvePosi;
         train_target_d = ResolveTarget;
      end else begin
         train_fire = cmt_fire & resolved_q[cmt_idx] & res_taken_q[cmt_idx];
      end
   end

   assign redirect_pc_d = ResolveTaken ? ResolveTarget : (pc_mem[ResolveIdx] + 32'd16);

   // Pointer and resolved-flag next state
   always_comb begin
      enq_d      = enq_q;
      fetch_d    = fetch_q;
      cmt_d      = cmt_q;
      resolved_d = resolved_q;
      if (enq_fire) begin
         enq_d               = enq_q + PtrOne;
         resolved_d[enq_idx] = 1'b0;
      end
      if (fetch_fire) begin
         fetch_d = fetch_q + PtrOne;
      end
      if (res_acc) begin
         resolved_d[ResolveIdx] = 1'b1;
      end
      if (mispred) begin
         enq_d   = mispred_ptr;
         fetch_d = mispred_ptr;
      end
      if (cmt_fire) begin
         cmt_d = cmt_q + PtrOne;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rest) begin
         enq_q         <= '0;
         fetch_q       <= '0;
         cmt_q         <= '0;
         resolved_q    <= '0;
         RedirectValid <= 1'b0;
         RedirectPc    <= '0;
         TrainValid    <= 1'b0;
         TrainTage     <= '0;
         TrainType     <= '0;
         TrainPosi     <= '0;
         TrainTarget   <= '0;
      end else begin
         enq_q         <= enq_d;
         fetch_q       <= fetch_d;
         cmt_q         <= cmt_d;
         resolved_q    <= resolved_d;
         RedirectValid <= mispred;
         TrainValid    <= train_fire;
         if (mispred) begin
            RedirectPc <= redirect_pc_d;
         end
         if (train_fire) begin
            TrainTage   <= pc_mem[cmt_idx][31:13];
            TrainType   <= train_type_d;
            TrainPosi   <= train_posi_d;
            TrainTarget <= train_target_d;
         end
      end
   end

   // Payload storage needs no reset: validity lives in the pointers and flags.
   always_ff @(posedge Clk) begin
      if (enq_fire) begin
         pc_mem[enq_idx]        <= BpuPc;
         next_pc_mem[enq_idx]   <= BpuNextPc;
         pred_type_mem[enq_idx] <= BpuType;
         posi_mem[enq_idx]      <= BpuPosi;
      end
      if (res_acc) begin
         res_taken_q[ResolveIdx]    <= ResolveTaken;
         res_type_mem[ResolveIdx]   <= ResolveType;
         res_posi_mem[ResolveIdx]   <= ResolvePosi;
         res_target_mem[ResolveIdx] <= ResolveTarget;
      end
   end

   // Predicted type is kept per entry for debug visibility; nothing here consumes it.
   logic unused_pred_type;
   assign unused_pred_type = ^pred_type_mem[fetch_idx];

endmodule

// File: tb/tb_ftq_unit.sv
module tb_ftq_unit;
   localparam int Depth = 8;

   logic        Clk = 1'b0;
   logic        Rest;
   logic        BpuValid, BpuReady;
   logic [31:0] BpuPc, BpuNextPc;
   logic [2:0]  BpuType, BpuPosi;
   logic        FetchValid, FetchReady;
   logic [31:0] FetchPc, FetchNextPc;
   logic [2:0]  FetchPosi, FetchIdx;
   logic        ResolveValid, ResolveTaken, ResolveMispred;
   logic [2:0]  ResolveIdx, ResolveType, ResolvePosi;
   logic [31:0] ResolveTarget;
   logic        CommitValid;
   logic        RedirectValid;
   logic [31:0] RedirectPc;
   logic        TrainValid;
   logic [18:0] TrainTage;
   logic [2:0]  TrainType, TrainPosi;
   logic [31:0] TrainTarget;

   always #5 Clk = ~Clk;

   ftq_unit #(.FTQ_DEPTH(8), .IDX_W(3)) dut (
      .Clk(Clk), .Rest(Rest),
      .BpuValid(BpuValid), .BpuReady(BpuReady), .BpuPc(BpuPc), .BpuNextPc(BpuNextPc),
      .BpuType(BpuType), .BpuPosi(BpuPosi),
      .FetchValid(FetchValid), .FetchReady(FetchReady), .FetchPc(FetchPc),
      .FetchNextPc(FetchNextPc), .FetchPosi(FetchPosi), .FetchIdx(FetchIdx),
      .ResolveValid(ResolveValid), .ResolveIdx(ResolveIdx), .ResolveTaken(ResolveTaken),
      .ResolveType(ResolveType), .ResolvePosi(ResolvePosi), .ResolveTarget(ResolveTarget),
      .ResolveMispred(ResolveMispred), .CommitValid(CommitValid),
      .RedirectValid(RedirectValid), .RedirectPc(RedirectPc),
      .TrainValid(TrainValid), .TrainTage(TrainTage), .TrainType(TrainType),
      .TrainPosi(TrainPosi), .TrainTarget(TrainTarget)
   );

   // Reference model: an ordered list of live blocks, oldest first.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [2:0]  ptype;
      logic [2:0]  posi;
      bit          resolved;
      bit          taken;
      logic [2:0]  rtype;
      logic [2:0]  rposi;
      logic [31:0] rtarget;
   } ent_t;

   ent_t mq[$];
   int   nfet;     // blocks already handed to fetch, counted from the oldest
   int   cmt_cnt;  // total blocks committed since reset
   int   checks;
   int   failures;

   bit          e_rv, e_tv;
   logic [31:0] e_rpc, e_ttarget;
   logic [18:0] e_ttag;
   logic [2:0]  e_ttype, e_tposi;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      BpuValid = 1'b0; BpuPc = '0; BpuNextPc = '0; BpuType = '0; BpuPosi = '0;
      FetchReady = 1'b0;
      ResolveValid = 1'b0; ResolveIdx = '0; ResolveTaken = 1'b0; ResolveType = '0;
      ResolvePosi = '0; ResolveTarget = '0; ResolveMispred = 1'b0;
      CommitValid = 1'b0;
   endtask

   task automatic bpu(input logic [31:0] pc);
      BpuValid = 1'b1; BpuPc = pc; BpuNextPc = pc + 32'h40;
      BpuType = 3'(pc[6:4]); BpuPosi = 3'(pc[9:7]);
   endtask

   task automatic resolve(input int idx, input bit taken, input bit mis, input logic [31:0] tgt);
      ResolveValid = 1'b1; ResolveIdx = 3'(idx); ResolveTaken = taken;
      ResolveMispred = mis; ResolveTarget = tgt;
      ResolveType = 3'(idx + 1); ResolvePosi = 3'(idx + 2);
   endtask

   task automatic do_reset();
      Rest = 1'b1;
      @(posedge Clk); #1;
      Rest = 1'b0;
      set_idle();
      mq.delete(); nfet = 0; cmt_cnt = 0;
      #1;
      chk("rst_bpu_ready", 32'(BpuReady), 32'd1);
      chk("rst_fetch_valid", 32'(FetchValid), 32'd0);
      chk("rst_redirect_valid", 32'(RedirectValid), 32'd0);
      chk("rst_train_valid", 32'(TrainValid), 32'd0);
      chk("rst_fetch_pc", FetchPc, 32'd0);
      chk("rst_fetch_idx", 32'(FetchIdx), 32'd0);
      chk("rst_redirect_pc", RedirectPc, 32'd0);
      chk("rst_train_tag", 32'(TrainTage), 32'd0);
      chk("rst_train_target", TrainTarget, 32'd0);
   endtask

   // One clock: check combinational outputs mid-cycle, advance the model, then
   // check the registered outputs just after the edge.
   task automatic step();
      bit   full, ready, fv, acc, mis, enq, fet, com;
      int   k;
      ent_t e;
      @(negedge Clk);
      full  = (mq.size() == Depth);
      ready = !full && !(ResolveValid && ResolveMispred);
      fv    = (nfet < mq.size());
      chk("bpu_ready", 32'(BpuReady), 32'(ready));
      chk("fetch_valid", 32'(FetchValid), 32'(fv));
      if (fv) begin
         chk("fetch_pc", FetchPc, mq[nfet].pc);
         chk("fetch_next_pc", FetchNextPc, mq[nfet].npc);
         chk("fetch_posi", 32'(FetchPosi), 32'(mq[nfet].posi));
         chk("fetch_idx", 32'(FetchIdx), 32'((cmt_cnt + nfet) % Depth));
      end
      k   = (int'(ResolveIdx) - (cmt_cnt % Depth) + Depth) % Depth;
      acc = ResolveValid && (k < nfet);
      mis = acc && ResolveMispred;
      enq = BpuValid && ready;
      fet = fv && FetchReady && !mis;
      com = CommitValid && (nfet > 0);
      if (acc) begin
         e = mq[k];
         e.resolved = 1'b1; e.taken = ResolveTaken; e.rtype = ResolveType;
         e.rposi = ResolvePosi; e.rtarget = ResolveTarget;
         mq[k] = e;
      end
      e_rv = mis;
      if (mis) e_rpc = ResolveTaken ? ResolveTarget : mq[k].pc + 32'd16;
      e_tv = com && mq[0].resolved && mq[0].taken;
      if (e_tv) begin
         e_ttag = mq[0].pc[31:13]; e_ttype = mq[0].rtype;
         e_tposi = mq[0].rposi; e_ttarget = mq[0].rtarget;
      end
      if (mis) begin
         while (mq.size() > k + 1) void'(mq.pop_back());
         nfet = k + 1;
      end else begin
         if (fet) nfet++;
         if (enq) begin
            e = '{pc: BpuPc, npc: BpuNextPc, ptype: BpuType, posi: BpuPosi,
                  resolved: 1'b0, taken: 1'b0, rtype: '0, rposi: '0, rtarget: '0};
            mq.push_back(e);
         end
      end
      if (com) begin
         void'(mq.pop_front());
         nfet--;
         cmt_cnt++;
      end
      @(posedge Clk); #1;
      chk("redirect_valid", 32'(RedirectValid), 32'(e_rv));
      if (e_rv) chk("redirect_pc", RedirectPc, e_rpc);
      chk("train_valid", 32'(TrainValid), 32'(e_tv));
      if (e_tv) begin
         chk("train_tag", 32'(TrainTage), 32'(e_ttag));
         chk("train_type", 32'(TrainType), 32'(e_ttype));
         chk("train_posi", 32'(TrainPosi), 32'(e_tposi));
         chk("train_target", TrainTarget, e_ttarget);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      set_idle();
      do_reset();

      // Fill and drain
      for (int i = 0; i < 8; i++) begin
         set_idle(); bpu(32'h1000 + 32'(16 * i)); step();
      end
      set_idle(); #1;
      chk("full_ready", 32'(BpuReady), 32'd0);
      for (int i = 0; i < 8; i++) begin
         set_idle(); FetchReady = 1'b1; #1;
         chk("drain_pc", FetchPc, 32'h1000 + 32'(16 * i));
         chk("drain_idx", 32'(FetchIdx), 32'(i));
         step();
      end

      // Taken-branch training on the oldest entry
      set_idle(); resolve(0, 1'b1, 1'b0, 32'h2000);
      ResolveType = 3'd1; ResolvePosi = 3'd2;
      step();
      set_idle(); CommitValid = 1'b1; step();
      chk("train_pulse", 32'(TrainValid), 32'd1);
      chk("train_tag_dir", 32'(TrainTage), 32'(32'h1000 >> 13));
      chk("train_type_dir", 32'(TrainType), 32'd1);
      chk("train_posi_dir", 32'(TrainPosi), 32'd2);
      chk("train_target_dir", TrainTarget, 32'h2000);
      for (int i = 0; i < 8; i++) begin
         set_idle(); CommitValid = 1'b1; step();
      end

      // Mispredict flush, taken then not-taken
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_idle(); FetchReady = 1'b1;
         if (i < 5) bpu(32'h1000 + 32'(16 * i));
         step();
      end
      set_idle(); resolve(1, 1'b1, 1'b1, 32'h3000);
      bpu(32'h9000); FetchReady = 1'b1;
      step();
      chk("mis_redirect_valid", 32'(RedirectValid), 32'd1);
      chk("mis_redirect_pc", RedirectPc, 32'h3000);
      set_idle(); #1;
      chk("mis_fetch_empty", 32'(FetchValid), 32'd0);
      set_idle(); bpu(32'h5000); step();
      set_idle(); #1;
      chk("mis_new_idx", 32'(FetchIdx), 32'd2);
      chk("mis_new_pc", FetchPc, 32'h5000);
      set_idle(); resolve(0, 1'b0, 1'b1, 32'h7777); step();
      chk("nt_redirect_pc", RedirectPc, 32'h1010);

      // Ignored resolve outside [cmt, fetch)
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_idle(); FetchReady = 1'b1;
         if (i < 3) bpu(32'h4000 + 32'(16 * i));
         step();
      end
      set_idle(); resolve(6, 1'b1, 1'b1, 32'h7000); bpu(32'h4100); step();
      chk("ign_no_redirect", 32'(RedirectValid), 32'd0);
      set_idle(); step();

      // Pointer wrap
      do_reset();
      for (int i = 0; i < 20; i++) begin
         set_idle(); bpu(32'h8000 + 32'(16 * i)); FetchReady = 1'b1; CommitValid = 1'b1;
         step();
      end
      for (int i = 0; i < 12 && mq.size() < Depth; i++) begin
         set_idle(); bpu(32'hA000 + 32'(16 * i)); step();
      end
      set_idle(); #1;
      chk("wrap_full", 32'(BpuReady), 32'd0);
      for (int i = 0; i < 24 && mq.size() > 0; i++) begin
         set_idle(); FetchReady = 1'b1; CommitValid = 1'b1; step();
      end
      set_idle(); #1;
      chk("wrap_empty_valid", 32'(FetchValid), 32'd0);
      chk("wrap_empty_ready", 32'(BpuReady), 32'd1);

      // Reset during a mispredict cycle
      for (int i = 0; i < 4; i++) begin
         set_idle(); FetchReady = 1'b1;
         if (i < 3) bpu(32'hC000 + 32'(16 * i));
         step();
      end
      set_idle(); resolve((cmt_cnt + 1) % Depth, 1'b1, 1'b1, 32'hD000);
      do_reset();
      set_idle(); step();
      chk("rst_mid_no_redirect", 32'(RedirectValid), 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         set_idle();
         if ($urandom_range(3, 0) != 0) bpu($urandom() & 32'hFFFF_FFF0);
         FetchReady = ($urandom_range(2, 0) != 0);
         if ($urandom_range(1, 0) != 0) begin
            resolve((cmt_cnt + int'($urandom_range(7, 0))) % Depth,
                    1'($urandom_range(1, 0)), ($urandom_range(9, 0) == 0),
                    $urandom() & 32'hFFFF_FFFC);
            ResolveType = 3'($urandom_range(7, 0));
            ResolvePosi = 3'($urandom_range(7, 0));
         end
         CommitValid = ($urandom_range(2, 0) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
